binary_to_bcd_seq: RTL

- Iterative (shift-add-3 / double-dabble) binary-to-packed-BCD converter with a valid/ready handshake.
- Parametrised in input width and output digit count.
- Replaces the per-field combinational converters in the clock display path: one shared instance serially converts hours, minutes and seconds, plus future date/alarm fields, at one input bit per clock.
- Adds explicit overflow detection and saturation for values that do not fit in DIGITS decimal digits.

---
 rtl/binary_to_bcd_seq_if.sv | 22 ++
 rtl/binary_to_bcd_seq.sv | 94 +++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq_if.sv
// rtl/binary_to_bcd_seq_if.sv - request/result handshake bundle for the serial binary-to-BCD converter
interface binary_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 7,
  parameter int DIGITS    = 2
);
  logic                  i_valid;
  logic [BIN_WIDTH-1:0]  i_binary;
  logic                  o_ready;
  logic                  o_valid;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_overflow;

  modport master (
    output i_valid, i_binary,
    input  o_ready, o_valid, o_bcd, o_overflow
  );

  modport slave (
    input  i_valid, i_binary,
    output o_ready, o_valid, o_bcd, o_overflow
  );
endinterface

// File: rtl/binary_to_bcd_seq.sv
// rtl/binary_to_bcd_seq.sv - iterative double-dabble converter, one input bit per clock, saturating on overflow
module binary_to_bcd_seq #(
  parameter int BIN_WIDTH = 7,
  parameter int DIGITS    = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  binary_to_bcd_seq_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                state_q;
  logic [BIN_WIDTH-1:0]  shift_q;
  logic [BW-1:0]         acc_q;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [BW-1:0]         bcd_q;
  logic                  ovf_out_q;

  logic [BW-1:0]         acc_adj_d;
  logic [BW-1:0]         acc_d;
  logic                  ovf_d;

  // Digits are corrected independently; a carry out of the top digit is lost and flagged instead.
  always_comb begin
    acc_adj_d = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj_d[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    acc_d = {acc_adj_d[BW-2:0], shift_q[BIN_WIDTH-1]};
    ovf_d = ovf_q | acc_adj_d[BW-1];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.i_valid) begin
            shift_q <= bus.i_binary;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(BIN_WIDTH - 1);
            ready_q <= 1'b0;
            state_q <= S_SHIFT;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          acc_q   <= acc_d;
          shift_q <= {shift_q[BIN_WIDTH-2:0], 1'b0};
          ovf_q   <= ovf_d;
          if (cnt_q == '0) begin
            state_q   <= S_DONE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b1;
            bcd_q     <= ovf_d ? {DIGITS{4'h9}} : acc_d;
            ovf_out_q <= ovf_d;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_bcd      = bcd_q;
  assign bus.o_overflow = ovf_out_q;
endmodule
